// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash controllers: sequencer states and opcodes.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_A2,
        ST_A1,
        ST_A0,
        ST_DATA,
        ST_DESEL,
        ST_DONE
    } state_t;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RDSR      = 8'h05;

    localparam logic [7:0] READ_CMD_DEFAULT = OP_READ;

endpackage

// File: rtl/spi_flash_read_ctrl.sv
// SPI flash READ sequencer: opcode, 24-bit address, then len data bytes streamed
// into a fifo, one byte in flight at a time, with abort and CS high-time guard.
module spi_flash_read_ctrl
    import spi_flash_pkg::*;
#(
    parameter logic [7:0] READ_CMD       = READ_CMD_DEFAULT,
    parameter int         LEN_BITS       = 16,
    parameter int         CS_HIGH_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [23:0]         addr,
    input  logic [LEN_BITS-1:0] len,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                spi_cs_n,
    output logic                spi_start,
    output logic [7:0]          spi_tx_data,
    input  logic                spi_ready,
    input  logic                spi_done,
    input  logic [7:0]          spi_rx_data,
    input  logic                fifo_space_available,
    output logic [7:0]          fifo_write_data,
    output logic                fifo_write_strobe
);

    localparam int CW = $clog2(CS_HIGH_CYCLES + 1);

    state_t                state;
    logic [23:0]           addr_q;
    logic [LEN_BITS-1:0]   remaining;
    logic                  outstanding;
    logic                  abort_pend;
    logic [CW-1:0]         cs_cnt;
    logic [7:0]            next_byte;
    logic                  can_issue;

    always_comb begin
        next_byte = 8'h00;
        case (state)
            ST_CMD:  next_byte = READ_CMD;
            ST_A2:   next_byte = addr_q[23:16];
            ST_A1:   next_byte = addr_q[15:8];
            ST_A0:   next_byte = addr_q[7:0];
            default: next_byte = 8'h00;
        endcase
    end

    // Data dummies also need fifo room; the single-outstanding rule absorbs
    // the one-cycle lag of the fifo's registered space flag.
    always_comb begin
        can_issue = 1'b0;
        if (!outstanding && spi_ready) begin
            case (state)
                ST_CMD, ST_A2, ST_A1, ST_A0: can_issue = 1'b1;
                ST_DATA: can_issue = (remaining != '0) && fifo_space_available;
                default: can_issue = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            addr_q            <= '0;
            remaining         <= '0;
            outstanding       <= 1'b0;
            abort_pend        <= 1'b0;
            cs_cnt            <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            spi_cs_n          <= 1'b1;
            spi_start         <= 1'b0;
            spi_tx_data       <= 8'h00;
            fifo_write_data   <= 8'h00;
            fifo_write_strobe <= 1'b0;
        end else begin
            spi_start         <= 1'b0;
            fifo_write_strobe <= 1'b0;
            done              <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len == '0) begin
                            state <= ST_DONE;
                        end else begin
                            addr_q     <= addr;
                            remaining  <= len;
                            abort_pend <= 1'b0;
                            spi_cs_n   <= 1'b0;
                            state      <= ST_CMD;
                            // Opcode goes out immediately when the engine is free.
                            if (spi_ready) begin
                                spi_start   <= 1'b1;
                                spi_tx_data <= READ_CMD;
                                outstanding <= 1'b1;
                            end
                        end
                    end
                end

                ST_CMD, ST_A2, ST_A1, ST_A0, ST_DATA: begin
                    if (outstanding && spi_done) begin
                        outstanding <= 1'b0;
                        if (abort || abort_pend) begin
                            state      <= ST_DESEL;
                            spi_cs_n   <= 1'b1;
                            cs_cnt     <= '0;
                            abort_pend <= 1'b0;
                        end else begin
                            case (state)
                                ST_CMD: state <= ST_A2;
                                ST_A2:  state <= ST_A1;
                                ST_A1:  state <= ST_A0;
                                ST_A0:  state <= ST_DATA;
                                default: begin
                                    fifo_write_data   <= spi_rx_data;
                                    fifo_write_strobe <= 1'b1;
                                    remaining         <= remaining - 1'b1;
                                    if (remaining == LEN_BITS'(1)) begin
                                        state    <= ST_DESEL;
                                        spi_cs_n <= 1'b1;
                                        cs_cnt   <= '0;
                                    end
                                end
                            endcase
                        end
                    end else if (abort || abort_pend) begin
                        // Let an in-flight byte finish; its data is dropped above.
                        if (outstanding) begin
                            abort_pend <= 1'b1;
                        end else begin
                            state      <= ST_DESEL;
                            spi_cs_n   <= 1'b1;
                            cs_cnt     <= '0;
                            abort_pend <= 1'b0;
                        end
                    end else if (can_issue) begin
                        spi_start   <= 1'b1;
                        spi_tx_data <= next_byte;
                        outstanding <= 1'b1;
                    end
                end

                ST_DESEL: begin
                    if (cs_cnt == CW'(CS_HIGH_CYCLES - 1)) state <= ST_DONE;
                    else                                  cs_cnt <= cs_cnt + 1'b1;
                end

                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
